// File: rtl/ysyx_23060208_lsu.sv
// Multi-cycle load/store unit: aligns store lanes, issues one SRAM request per access,
// extracts and extends load data, and hands the result to write-back over valid/ready.
module ysyx_23060208_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [4:0]            in_load_inst,
    input  logic [2:0]            in_store_inst,
    input  logic [REG_WIDTH-1:0]  in_rd,
    input  logic                  in_rf_wen,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  mem_resp_err,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_WIDTH-1:0]  wb_rd,
    output logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  wb_wen,
    output logic                  wb_fault
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_req_wdata;
    logic [3:0]              r_req_wstrb;
    logic                    r_we;
    logic [4:0]              r_load;
    logic                    r_is_store;
    logic [REG_WIDTH-1:0]    r_rd;
    logic                    r_rf_wen;
    logic                    r_fault;
    logic [DATA_WIDTH-1:0]   r_wb_wdata;

    logic                    w_accept;
    logic                    w_resp;
    logic [1:0]              w_off;
    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_word;
    logic                    w_half_acc;
    logic                    w_misalign;
    logic [7:0]              w_sel;
    logic                    w_illegal;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [3:0]              w_wstrb;
    logic [15:0]             w_half;
    logic [7:0]              w_byte;
    logic [DATA_WIDTH-1:0]   w_load_data;

    assign w_accept   = in_valid && (r_state == StIdle);
    assign w_resp     = mem_resp_valid && (r_state == StWait);
    assign w_off      = in_alu_result[1:0];
    assign w_is_load  = |in_load_inst;
    assign w_is_store = |in_store_inst;
    assign w_word     = in_load_inst[0] | in_store_inst[0];
    assign w_half_acc = in_load_inst[1] | in_load_inst[2] | in_store_inst[1];
    assign w_misalign = (w_word && (w_off != 2'b00)) || (w_half_acc && w_off[0]);
    // Clearing the lowest set bit leaves something only if more than one type bit is set.
    assign w_sel      = {in_load_inst, in_store_inst};
    assign w_illegal  = (w_sel & (w_sel - 8'd1)) != 8'd0;

    always_comb begin
        w_wdata = in_store_data;
        w_wstrb = 4'b0000;
        if (in_store_inst[0]) begin
            w_wstrb = 4'b1111;
        end else if (in_store_inst[1]) begin
            w_wstrb = 4'b0011 << w_off;
            w_wdata = {2{in_store_data[15:0]}};
        end else if (in_store_inst[2]) begin
            w_wstrb = 4'b0001 << w_off;
            w_wdata = {4{in_store_data[7:0]}};
        end
    end

    always_comb begin
        w_half = r_addr[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
        case (r_addr[1:0])
            2'd0:    w_byte = mem_resp_rdata[7:0];
            2'd1:    w_byte = mem_resp_rdata[15:8];
            2'd2:    w_byte = mem_resp_rdata[23:16];
            default: w_byte = mem_resp_rdata[31:24];
        endcase
        w_load_data = mem_resp_rdata;
        if (r_load[1]) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (r_load[2]) begin
            w_load_data = {16'd0, w_half};
        end else if (r_load[3]) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (r_load[4]) begin
            w_load_data = {24'd0, w_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_illegal || w_misalign || !(w_is_load || w_is_store)) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (wb_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= 4'b0000;
            r_we        <= 1'b0;
            r_load      <= 5'b00000;
            r_is_store  <= 1'b0;
            r_rd        <= '0;
            r_rf_wen    <= 1'b0;
            r_fault     <= 1'b0;
            r_wb_wdata  <= '0;
        end else if (w_accept) begin
            r_addr      <= in_alu_result;
            r_req_wdata <= w_wdata;
            r_req_wstrb <= w_wstrb;
            r_we        <= w_is_store;
            r_load      <= in_load_inst;
            r_is_store  <= w_is_store;
            r_rd        <= in_rd;
            r_rf_wen    <= in_rf_wen;
            r_fault     <= w_illegal || w_misalign;
            // Non-memory results are final at capture; memory results arrive later.
            if (!w_illegal && !w_misalign && !w_is_load && !w_is_store) begin
                r_wb_wdata <= in_alu_result;
            end else begin
                r_wb_wdata <= '0;
            end
        end else if (w_resp) begin
            r_fault <= mem_resp_err;
            if (mem_resp_err || r_is_store) begin
                r_wb_wdata <= '0;
            end else begin
                r_wb_wdata <= w_load_data;
            end
        end
    end

    assign in_ready      = (r_state == StIdle);
    assign mem_req_valid = (r_state == StReq);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wstrb = r_req_wstrb;
    assign wb_valid      = (r_state == StDone);
    assign wb_rd         = r_rd;
    assign wb_wdata      = r_wb_wdata;
    assign wb_wen        = r_rf_wen & ~r_is_store & ~r_fault;
    assign wb_fault      = r_fault;

endmodule
